// File: rtl/spi_flash_seq_arbiter_pkg.sv
// Shared definitions for the SPI flash sequencer: FSM states, opcodes, address width.
package spi_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SEND_CMD,
    SEND_ADDR,
    READ_DATA,
    CS_HOLD
  } seq_state_t;

  localparam logic [7:0]  RDID     = 8'h9F;
  localparam logic [7:0]  READ     = 8'h03;
  localparam logic [7:0]  DUMMY_TX = 8'h00;
  localparam int unsigned ADDR_W   = 24;

  // Address bytes go out MSB first: index 0 is addr[23:16].
  function automatic logic [7:0] addr_byte(input logic [ADDR_W-1:0] addr,
                                           input logic [1:0]        idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = addr[23:16];
      2'd1:    b = addr[15:8];
      default: b = addr[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_flash_seq_arbiter_arb.sv
// Two-input round-robin arbiter; the pointer remembers the last winner.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic [1:0] last_grant;

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant[0] ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  // Reset pointer says requester 1 went last, so requester 0 wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_grant <= 2'b10;
    else if (update && (|req))
      last_grant <= grant;
  end

endmodule

// File: rtl/spi_flash_seq_arbiter.sv
// Round-robin sequencer sharing one SPI byte engine between two flash clients.
// Optional byte-transfer watchdog enabled by defining SPI_SEQ_TIMEOUT_EN.
module spi_flash_seq_arbiter #(
  parameter int unsigned LEN_W          = 8,
  parameter int unsigned CS_HIGH_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req,
  input  logic [15:0]          req_opcode,
  input  logic [47:0]          req_addr,
  input  logic [1:0]           req_has_addr,
  input  logic [2*LEN_W-1:0]   req_len,
  output logic [1:0]           grant,
  output logic [7:0]           rd_data,
  output logic [1:0]           rd_valid,
  output logic [1:0]           done,
  output logic [1:0]           err,
  output logic                 busy,
  output logic                 eng_start,
  output logic [7:0]           eng_tx,
  input  logic                 eng_done,
  input  logic [7:0]           eng_rx,
  output logic                 chip_select
);

  import spi_seq_pkg::*;

  localparam int unsigned HOLD_W = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CS_HIGH_CYCLES - 1);

  seq_state_t         state, state_nxt;
  logic [1:0]         arb_grant;
  logic               arb_update;
  logic               winner_hi;
  logic [1:0]         grant_q;
  logic [7:0]         op_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               has_addr_q;
  logic [LEN_W-1:0]   remain_q;
  logic               pending;
  logic               xfer_done;
  logic               xfer_timeout;
  logic               timed_out;
  logic [1:0]         addr_idx;
  logic [HOLD_W-1:0]  hold_cnt;

  assign arb_update = (state == IDLE);
  assign winner_hi  = arb_grant[1];
  assign grant      = grant_q;
  // eng_done only counts while a transfer we started is outstanding.
  assign xfer_done  = pending && eng_done;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .update (arb_update),
    .grant  (arb_grant)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (|req) state_nxt = CS_SETUP;
      CS_SETUP:  state_nxt = SEND_CMD;
      SEND_CMD:
        if (xfer_done) begin
          if (has_addr_q)            state_nxt = SEND_ADDR;
          else if (remain_q != '0)   state_nxt = READ_DATA;
          else                       state_nxt = CS_HOLD;
        end
      SEND_ADDR:
        if (xfer_done && addr_idx == 2'd2)
          state_nxt = (remain_q != '0) ? READ_DATA : CS_HOLD;
      READ_DATA:
        if (xfer_done && remain_q == LEN_W'(1)) state_nxt = CS_HOLD;
      CS_HOLD:   if (hold_cnt == HOLD_LAST) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (xfer_timeout) state_nxt = CS_HOLD;
  end

  always_comb begin
    chip_select = 1'b1;
    busy        = (state != IDLE);
    eng_start   = 1'b0;
    eng_tx      = '0;
    rd_valid    = '0;
    rd_data     = '0;
    done        = '0;
    err         = '0;
    case (state)
      CS_SETUP: chip_select = 1'b0;
      SEND_CMD: begin
        chip_select = 1'b0;
        eng_start   = !pending;
        eng_tx      = op_q;
      end
      SEND_ADDR: begin
        chip_select = 1'b0;
        eng_start   = !pending;
        eng_tx      = addr_byte(addr_q, addr_idx);
      end
      READ_DATA: begin
        chip_select = 1'b0;
        eng_start   = !pending;
        eng_tx      = DUMMY_TX;
        if (xfer_done && !timed_out) begin
          rd_valid = grant_q;
          rd_data  = eng_rx;
        end
      end
      CS_HOLD:
        if (hold_cnt == '0) begin
          done = grant_q;
          err  = timed_out ? grant_q : '0;
        end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q    <= '0;
      op_q       <= '0;
      addr_q     <= '0;
      has_addr_q <= 1'b0;
      remain_q   <= '0;
      pending    <= 1'b0;
      addr_idx   <= '0;
      hold_cnt   <= '0;
    end else begin
      if (state == IDLE && (|req)) begin
        grant_q    <= arb_grant;
        op_q       <= winner_hi ? req_opcode[15:8]          : req_opcode[7:0];
        addr_q     <= winner_hi ? req_addr[47:24]           : req_addr[23:0];
        has_addr_q <= winner_hi ? req_has_addr[1]           : req_has_addr[0];
        remain_q   <= winner_hi ? req_len[2*LEN_W-1:LEN_W]  : req_len[LEN_W-1:0];
      end else if (state == CS_HOLD && hold_cnt == HOLD_LAST) begin
        grant_q <= '0;
      end else if (state == READ_DATA && xfer_done) begin
        remain_q <= remain_q - LEN_W'(1);
      end

      if (eng_start)                      pending <= 1'b1;
      else if (xfer_done || xfer_timeout) pending <= 1'b0;

      if (state != SEND_ADDR) addr_idx <= '0;
      else if (xfer_done)     addr_idx <= addr_idx + 2'd1;

      if (state == CS_HOLD) hold_cnt <= hold_cnt + HOLD_W'(1);
      else                  hold_cnt <= '0;
    end
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  assign xfer_timeout = pending && !eng_done && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt    <= '0;
      timed_out <= 1'b0;
    end else begin
      if (eng_start)    to_cnt <= '0;
      else if (pending) to_cnt <= to_cnt + TO_W'(1);
      if (xfer_timeout)       timed_out <= 1'b1;
      else if (state == IDLE) timed_out <= 1'b0;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign xfer_timeout       = 1'b0;
  assign timed_out          = 1'b0;
`endif

endmodule

// File: tb/tb_spi_flash_seq_arbiter.sv
// Directed bench for spi_flash_seq_arbiter with a behavioural byte engine.
module tb_spi_flash_seq_arbiter;
  import spi_seq_pkg::*;

  localparam int unsigned LEN_W = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic [1:0]         req;
  logic [15:0]        req_opcode;
  logic [47:0]        req_addr;
  logic [1:0]         req_has_addr;
  logic [2*LEN_W-1:0] req_len;
  logic [1:0]         grant, rd_valid, done, err;
  logic [7:0]         rd_data, eng_tx;
  logic               busy, eng_start, chip_select;
  logic               eng_done = 1'b0;
  logic [7:0]         eng_rx   = 8'h00;

  spi_flash_seq_arbiter #(.LEN_W(LEN_W), .CS_HIGH_CYCLES(4), .TIMEOUT_CYCLES(1024)) dut (
    .clk(clk), .reset(reset), .req(req), .req_opcode(req_opcode), .req_addr(req_addr),
    .req_has_addr(req_has_addr), .req_len(req_len), .grant(grant), .rd_data(rd_data),
    .rd_valid(rd_valid), .done(done), .err(err), .busy(busy), .eng_start(eng_start),
    .eng_tx(eng_tx), .eng_done(eng_done), .eng_rx(eng_rx), .chip_select(chip_select)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0, errors = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  // Byte engine: each accepted start completes two cycles later, rx bytes from rx_q.
  logic [7:0]  rx_q[$];
  logic [7:0]  tx_log[$];
  int unsigned eng_busy = 0, overlap_err = 0;
  bit          stall = 1'b0;
  always @(posedge clk) begin
    #1;
    if (reset) begin
      eng_busy = 0;
      eng_done = 1'b0;
      rx_q.delete();
    end else begin
      eng_done = 1'b0;
      if (eng_busy > 0) begin
        eng_busy--;
        if (eng_busy == 0) begin
          eng_done = 1'b1;
          eng_rx   = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h5A;
        end
      end
      if (eng_start) begin
        if (eng_busy > 0 || eng_done) overlap_err++;
        tx_log.push_back(eng_tx);
        if (!stall) eng_busy = 2;
      end
    end
  end

  logic [7:0]  rd0[$], rd1[$];
  logic [1:0]  grant_log[$];
  logic [1:0]  prev_grant = '0, exp_gchk = '0;
  int unsigned done0 = 0, done1 = 0, bad_rdv = 0, grant_viol = 0;
  int unsigned edone_cyc = 0, done_cyc = 0, hi_run = 0, min_hi = 1000;
  bit          seen_low = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (rd_valid[0]) rd0.push_back(rd_data);
      if (rd_valid[1]) rd1.push_back(rd_data);
      if (rd_valid != 2'b00 && rd_valid != grant) bad_rdv++;
      if (done[0]) done0++;
      if (done[1]) done1++;
      if (eng_done) edone_cyc = cyc;
      if (|done) done_cyc = cyc;
      if (busy && exp_gchk != 2'b00 && grant !== exp_gchk) grant_viol++;
      if (grant != 2'b00 && prev_grant == 2'b00) grant_log.push_back(grant);
      prev_grant = grant;
      if (chip_select) hi_run++;
      else begin
        if (seen_low && hi_run > 0 && hi_run < min_hi) min_hi = hi_run;
        seen_low = 1'b1;
        hi_run   = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_seq(input string tag, input logic [7:0] got[$],
                           input int unsigned base, input logic [7:0] exp[$]);
    check({tag, "_len"}, got.size() - base, exp.size());
    foreach (exp[i])
      if (base + i < got.size()) check($sformatf("%s_%0d", tag, i), got[base+i], exp[i]);
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int unsigned bound, output logic [1:0] seen);
    int unsigned n = 0;
    seen = '0;
    while (n < bound && seen == 2'b00) begin
      @(negedge clk);
      seen = done;
      n++;
    end
    if (seen == 2'b00) begin
      checks++; errors++;
      $error("FAIL %s no done within %0d cycles", tag, bound);
    end
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n = 0;
    while (n < 50 && busy) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++; errors++;
      $error("FAIL %s busy still high after %0d cycles", tag, n);
    end
  endtask

  initial begin
    logic [7:0]  exp[$];
    logic [1:0]  seen;
    int unsigned tb, r0, r1, d0, d1, gb, n;

    reset = 1'b1; req = '0; req_opcode = '0; req_addr = '0; req_has_addr = '0; req_len = '0;
    cycles(3);
    check("rst_cs", chip_select, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant, 2'b00);
    check("rst_start", eng_start, 1'b0);
    check("rst_done", done, 2'b00);
    check("rst_rdv", rd_valid, 2'b00);
    reset = 1'b0;
    cycles(2);

    // RDID on requester 0, three data bytes
    tb = tx_log.size(); r0 = rd0.size(); r1 = rd1.size(); d0 = done0;
    req_opcode[7:0] = RDID; req_has_addr[0] = 1'b0; req_len[7:0] = 8'd3;
    rx_q.push_back(8'hFF); rx_q.push_back(8'h20); rx_q.push_back(8'hBA); rx_q.push_back(8'h18);
    req = 2'b01;
    wait_done("t1_done", 200, seen);
    check("t1_done_vec", seen, 2'b01);
    check("t1_grant_at_done", grant, 2'b01);
    check("t1_cs_at_done", chip_select, 1'b1);
    req = 2'b00;
    wait_idle("t1_idle");
    cycles(2);
    exp = '{8'h9F, 8'h00, 8'h00, 8'h00};
    check_seq("t1_tx", tx_log, tb, exp);
    exp = '{8'h20, 8'hBA, 8'h18};
    check_seq("t1_rd0", rd0, r0, exp);
    check("t1_rd1_none", rd1.size() - r1, 0);
    check("t1_done_cnt", done0 - d0, 1);
    check("t1_grant_clear", grant, 2'b00);

    // READ with address on requester 1
    tb = tx_log.size(); r0 = rd0.size(); r1 = rd1.size(); d1 = done1;
    req_opcode[15:8] = READ; req_addr[47:24] = 24'h012345; req_has_addr[1] = 1'b1; req_len[15:8] = 8'd2;
    repeat (4) rx_q.push_back(8'hFF);
    rx_q.push_back(8'h11); rx_q.push_back(8'h22);
    exp_gchk = 2'b10;
    req = 2'b10;
    wait_done("t2_done", 200, seen);
    check("t2_done_vec", seen, 2'b10);
    req = 2'b00;
    wait_idle("t2_idle");
    exp_gchk = 2'b00;
    cycles(1);
    exp = '{8'h03, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00};
    check_seq("t2_tx", tx_log, tb, exp);
    exp = '{8'h11, 8'h22};
    check_seq("t2_rd1", rd1, r1, exp);
    check("t2_rd0_none", rd0.size() - r0, 0);
    check("t2_done_cnt", done1 - d1, 1);
    check("t2_grant_steady", grant_viol, 0);

    // Both requesting continuously: strict alternation
    tb = tx_log.size(); r0 = rd0.size(); r1 = rd1.size(); gb = grant_log.size();
    req_opcode = {READ, RDID}; req_has_addr = 2'b00; req_len = {8'd1, 8'd1};
    rx_q.push_back(8'hFF); rx_q.push_back(8'hA1); rx_q.push_back(8'hFF); rx_q.push_back(8'hA2);
    rx_q.push_back(8'hFF); rx_q.push_back(8'hA3); rx_q.push_back(8'hFF); rx_q.push_back(8'hA4);
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_done($sformatf("t3_done%0d", k), 200, seen);
      if (k == 3) req = 2'b00;
    end
    wait_idle("t3_idle");
    cycles(1);
    check("t3_grant_cnt", grant_log.size() - gb, 4);
    for (int k = 0; k < 4; k++)
      if (gb + k < grant_log.size())
        check($sformatf("t3_grant%0d", k), grant_log[gb+k], (k % 2 == 0) ? 2'b01 : 2'b10);
    exp = '{8'hA1, 8'hA3};
    check_seq("t3_rd0", rd0, r0, exp);
    exp = '{8'hA2, 8'hA4};
    check_seq("t3_rd1", rd1, r1, exp);
    exp = '{8'h9F, 8'h00, 8'h03, 8'h00, 8'h9F, 8'h00, 8'h03, 8'h00};
    check_seq("t3_tx", tx_log, tb, exp);
    check("t3_cs_high_min", (min_hi >= 4) ? 1 : 0, 1);

    // Opcode-only transaction
    tb = tx_log.size(); r0 = rd0.size(); d0 = done0;
    req_opcode[7:0] = RDID; req_has_addr = 2'b00; req_len = '0;
    rx_q.push_back(8'hFF);
    req = 2'b01;
    wait_done("t4_done", 200, seen);
    req = 2'b00;
    wait_idle("t4_idle");
    cycles(1);
    exp = '{8'h9F};
    check_seq("t4_tx", tx_log, tb, exp);
    check("t4_rd_none", rd0.size() - r0, 0);
    check("t4_done_cnt", done0 - d0, 1);
    check("t4_done_latency", done_cyc - edone_cyc, 1);

    // Reset during the second data byte
    tb = tx_log.size(); r0 = rd0.size(); d0 = done0; d1 = done1;
    req_opcode[7:0] = READ; req_has_addr = 2'b00; req_len[7:0] = 8'd3;
    rx_q.push_back(8'hFF); rx_q.push_back(8'h31); rx_q.push_back(8'h32); rx_q.push_back(8'h33);
    req = 2'b01;
    n = 0;
    while (n < 200 && rd0.size() == r0) begin
      @(negedge clk);
      n++;
    end
    check("t5_byte1_seen", rd0.size() - r0, 1);
    cycles(2);
    check("t5_cs_before", chip_select, 1'b0);
    reset = 1'b1;
    #1;
    check("t5_cs_async", chip_select, 1'b1);
    check("t5_busy_async", busy, 1'b0);
    check("t5_grant_async", grant, 2'b00);
    cycles(2);
    reset = 1'b0;
    req = 2'b00;
    cycles(2);
    check("t5_no_done", (done0 - d0) + (done1 - d1), 0);
    exp = '{8'h03, 8'h00, 8'h00};
    check_seq("t5_tx", tx_log, tb, exp);
    r0 = rd0.size(); r1 = rd1.size();
    req_opcode = {READ, RDID}; req_len = {8'd1, 8'd1};
    rx_q.push_back(8'hFF); rx_q.push_back(8'h41); rx_q.push_back(8'hFF); rx_q.push_back(8'h42);
    req = 2'b11;
    wait_done("t5_restart0", 200, seen);
    check("t5_first_winner", seen, 2'b01);
    req = 2'b10;
    wait_done("t5_restart1", 200, seen);
    check("t5_second_winner", seen, 2'b10);
    req = 2'b00;
    wait_idle("t5_idle");
    cycles(1);
    exp = '{8'h41};
    check_seq("t5_rd0", rd0, r0, exp);
    exp = '{8'h42};
    check_seq("t5_rd1", rd1, r1, exp);

`ifdef SPI_SEQ_TIMEOUT_EN
    // Engine never answers: watchdog closes the transaction with err
    stall = 1'b1;
    req_opcode[7:0] = RDID; req_has_addr = 2'b00; req_len = '0;
    req = 2'b01;
    wait_done("t6_done", 1200, seen);
    check("t6_done_vec", seen, 2'b01);
    check("t6_err_vec", err, 2'b01);
    check("t6_cs_high", chip_select, 1'b1);
    req = 2'b00;
    stall = 1'b0;
    wait_idle("t6_idle");
    check("t6_idle_busy", busy, 1'b0);
`endif

    check("eng_overlap", overlap_err, 0);
    check("rd_valid_owner", bad_rdv, 0);
    check("err_quiet_default", err, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_flash_seq_arbiter.md
Name: spi_flash_seq_arbiter

Overview:
- Shares one SPI byte engine between two requesters, e.g. the ID-read client and the boot/data-read client.
- Arbitrates requests round-robin.
- For the winner, sequences the transaction: chip-select assertion, 8-bit opcode, optional 24-bit address (MSB first), N read bytes, then chip-select deassertion with a minimum high time.
- Sits between the requesting clients and the byte engine that generates SPICLK/MOSI/MISO.

Parameters:
- LEN_W, 8, width of the byte-count field (max 2^LEN_W-1 data bytes).
- CS_HIGH_CYCLES, 4, minimum clk cycles chip_select stays high between transactions (>=1).
- TIMEOUT_CYCLES, 1024, watchdog limit per byte transfer (only with SPI_SEQ_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  2  per-requester request level; held until matching done pulse
- req_opcode  in  16  opcode, requester i on bits [8i+7:8i]
- req_addr  in  48  24-bit address, requester i on bits [24i+23:24i]
- req_has_addr  in  2  1 = send address phase
- req_len  in  2*LEN_W  data bytes to read, requester i on bits [LEN_W*i +: LEN_W]
- grant  out  2  one-hot owner of current transaction
- rd_data  out  8  received byte
- rd_valid  out  2  one-cycle pulse per byte, to granted requester only
- done  out  2  one-cycle pulse at transaction end
- err  out  2  one-cycle pulse on timeout (feature only; tied 0 otherwise)
- busy  out  1  high in any state other than IDLE
- eng_start  out  1  one-cycle pulse to start one byte transfer
- eng_tx  out  8  byte to shift out; stable from eng_start until eng_done
- eng_done  in  1  one-cycle pulse; byte transfer complete
- eng_rx  in  8  received byte, valid with eng_done
- chip_select  out  1  active-low flash select

Behaviour:
- Reset values: all outputs 0, except chip_select = 1. Last-granted pointer = 1, so requester 0 wins first.
- Reset mid-transaction: chip_select rises immediately (asynchronous). No done pulse is issued.
- States:
  - IDLE: if any req, latch the winner's opcode/addr/has_addr/len and set grant. Next cycle -> CS_SETUP.
  - CS_SETUP (1 cycle): chip_select = 0 -> SEND_CMD.
  - SEND_CMD: pulse eng_start with eng_tx = opcode; wait eng_done. Then -> SEND_ADDR if has_addr; else READ_DATA if len != 0; else CS_HOLD.
  - SEND_ADDR: three transfers, addr[23:16], [15:8], [7:0], each started the cycle after the previous eng_done. Then -> READ_DATA, or CS_HOLD if len == 0.
  - READ_DATA: eng_tx = 8'h00. On each eng_done: rd_data = eng_rx and rd_valid[g] pulses in the same cycle; remaining count decrements. At 0 -> CS_HOLD; otherwise start the next transfer next cycle.
  - CS_HOLD: chip_select = 1. done[g] pulses on the entry cycle. Stay CS_HIGH_CYCLES cycles, then -> IDLE, and grant clears on the IDLE entry.
- Arbitration: only in IDLE. A single request wins directly. If both requesters request, the one not granted last wins. A requester that re-asserts req immediately still waits out CS_HOLD.
- Request handshake:
  - Inputs are sampled only at grant; later changes are ignored.
  - Dropping req mid-transaction does not abort it.
  - A requester must drop req, or accept a repeat, on the cycle after done.
- chip_select is low from CS_SETUP through the final eng_done inclusive.
- eng_start is never asserted while a transfer is outstanding.
- Unexpected eng_done while not waiting: ignored.

Optional Feature:
- Macro: SPI_SEQ_TIMEOUT_EN.
- With it: a counter resets on each eng_start. If it reaches TIMEOUT_CYCLES without eng_done:
  - go to CS_HOLD;
  - pulse err[g] together with done[g];
  - suppress further rd_valid.
- Without it: no counter; err is tied 0 and the sequencer waits indefinitely.

Decomposition:
- Package spi_seq_pkg holds:
  - state encoding (IDLE, CS_SETUP, SEND_CMD, SEND_ADDR, READ_DATA, CS_HOLD);
  - opcode constants RDID = 8'h9F, READ = 8'h03, DUMMY_TX = 8'h00;
  - address width 24.
- One sub-module: rr_arbiter2 (two-input round-robin, last-grant pointer, grant update enable).

Test Plan:
- req[0]: opcode 9F, no address, len 3; engine returns 20,BA,18 -> eng_tx sequence 9F,00,00,00. rd_valid[0] pulses three times carrying 20,BA,18. One done[0]; chip_select high >= 4 cycles afterwards.
- req[1]: opcode 03, addr 0x012345, len 2 -> eng_tx 03,01,23,45,00,00. Two rd_valid[1] pulses, then done[1]; grant = 2'b10 throughout.
- req = 2'b11 held continuously -> grant order 01,10,01,10. Each grant is separated by CS_HOLD of >= CS_HIGH_CYCLES.
- len = 0, has_addr = 0 -> only the opcode is sent. done pulses the cycle after eng_done; no rd_valid.
- Reset asserted during READ_DATA byte 2 -> chip_select = 1 and busy = 0 immediately. No done. Next request restarts cleanly with requester 0 priority.
- SPI_SEQ_TIMEOUT_EN with eng_done withheld 1024 cycles -> err[g] and done[g] pulse together, chip_select rises, state returns to IDLE.
